// File: rtl/max7219_rx_monitor_if.sv
// MAX7219 receive monitor bus: serial pins and read port from the driver side,
// shadow register file and frame events from the monitor side.
interface max7219_rx_monitor_if;
    logic       MAX7219RX_din_In;
    logic       MAX7219RX_clk_In;
    logic       MAX7219RX_ncs_In;
    logic [2:0] MAX7219RX_rdAddr_In;
    logic [7:0] MAX7219RX_rdData_Out;
    logic [7:0] MAX7219RX_decodeMode_Out;
    logic [3:0] MAX7219RX_intensity_Out;
    logic [2:0] MAX7219RX_scanLimit_Out;
    logic       MAX7219RX_shutdownN_Out;
    logic       MAX7219RX_displayTest_Out;
    logic       MAX7219RX_frameValid_Out;
    logic [3:0] MAX7219RX_frameAddr_Out;
    logic [7:0] MAX7219RX_frameData_Out;
    logic       MAX7219RX_frameErr_Out;

    modport master (
        output MAX7219RX_din_In,
        output MAX7219RX_clk_In,
        output MAX7219RX_ncs_In,
        output MAX7219RX_rdAddr_In,
        input  MAX7219RX_rdData_Out,
        input  MAX7219RX_decodeMode_Out,
        input  MAX7219RX_intensity_Out,
        input  MAX7219RX_scanLimit_Out,
        input  MAX7219RX_shutdownN_Out,
        input  MAX7219RX_displayTest_Out,
        input  MAX7219RX_frameValid_Out,
        input  MAX7219RX_frameAddr_Out,
        input  MAX7219RX_frameData_Out,
        input  MAX7219RX_frameErr_Out
    );

    modport slave (
        input  MAX7219RX_din_In,
        input  MAX7219RX_clk_In,
        input  MAX7219RX_ncs_In,
        input  MAX7219RX_rdAddr_In,
        output MAX7219RX_rdData_Out,
        output MAX7219RX_decodeMode_Out,
        output MAX7219RX_intensity_Out,
        output MAX7219RX_scanLimit_Out,
        output MAX7219RX_shutdownN_Out,
        output MAX7219RX_displayTest_Out,
        output MAX7219RX_frameValid_Out,
        output MAX7219RX_frameAddr_Out,
        output MAX7219RX_frameData_Out,
        output MAX7219RX_frameErr_Out
    );
endinterface

// File: rtl/max7219_rx_monitor.sv
// Oversampling MAX7219 receiver: deserialises 16-bit frames from the
// DIN/CLK/NCS pins and keeps a shadow copy of the display register file.
module max7219_rx_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input logic                 MAX7219RX_CLOCK_50,
    input logic                 MAX7219RX_RESET_InLow,
    max7219_rx_monitor_if.slave bus
);
    localparam int SL = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] clkSync;
    logic [SYNC_STAGES-1:0] dinSync;
    logic [SYNC_STAGES-1:0] ncsSync;
    logic                   clkDly;
    logic                   ncsDly;

    logic                   clkS;
    logic                   dinS;
    logic                   ncsS;
    logic                   clkRise;
    logic                   ncsRise;
    logic                   ncsFall;
    logic                   shiftEn;

    // Only the low 12 bits of a frame are ever decoded, so only they are kept.
    logic [11:0]            sr;
    logic [11:0]            srNext;
    logic [4:0]             cnt;
    logic [4:0]             cntBase;
    logic [4:0]             cntNext;
    logic                   commitNow;
    logic                   errNow;

    logic                   pendValid;
    logic                   pendErr;
    logic [3:0]             pendAddr;
    logic [7:0]             pendData;
    logic [2:0]             digIdx;

    logic [7:0]             digit [8];
    logic [7:0]             rdData;
    logic [7:0]             decodeMode;
    logic [3:0]             intensity;
    logic [2:0]             scanLimit;
    logic                   shutdownN;
    logic                   displayTest;
    logic                   frameValid;
    logic                   frameErr;
    logic [3:0]             frameAddr;
    logic [7:0]             frameData;

    // NCS resets high so a deselected bus shows no edge after reset.
    always_ff @(posedge MAX7219RX_CLOCK_50 or negedge MAX7219RX_RESET_InLow) begin
        if (!MAX7219RX_RESET_InLow) begin
            clkSync <= '0;
            dinSync <= '0;
            ncsSync <= '1;
            clkDly  <= 1'b0;
            ncsDly  <= 1'b1;
        end else begin
            clkSync <= {clkSync[SYNC_STAGES-2:0], bus.MAX7219RX_clk_In};
            dinSync <= {dinSync[SYNC_STAGES-2:0], bus.MAX7219RX_din_In};
            ncsSync <= {ncsSync[SYNC_STAGES-2:0], bus.MAX7219RX_ncs_In};
            clkDly  <= clkSync[SL];
            ncsDly  <= ncsSync[SL];
        end
    end

    assign clkS    = clkSync[SL];
    assign dinS    = dinSync[SL];
    assign ncsS    = ncsSync[SL];
    assign clkRise = clkS & ~clkDly;
    assign ncsRise = ncsS & ~ncsDly;
    assign ncsFall = ~ncsS & ncsDly;
    // A clock edge coinciding with the deselect edge still belongs to the frame.
    assign shiftEn = clkRise & ~(ncsS & ncsDly);

    always_comb begin
        cntBase = ncsFall ? 5'd0 : cnt;
        cntNext = cntBase;
        srNext  = sr;
        if (shiftEn) begin
            srNext  = {sr[10:0], dinS};
            cntNext = (cntBase >= 5'd16) ? 5'd16 : cntBase + 5'd1;
        end
        commitNow = ncsRise && (cntNext >= 5'd16);
        errNow    = ncsRise && (cntNext != 5'd0) && (cntNext < 5'd16);
    end

    always_ff @(posedge MAX7219RX_CLOCK_50 or negedge MAX7219RX_RESET_InLow) begin
        if (!MAX7219RX_RESET_InLow) begin
            sr        <= '0;
            cnt       <= '0;
            pendValid <= 1'b0;
            pendErr   <= 1'b0;
            pendAddr  <= '0;
            pendData  <= '0;
        end else begin
            sr        <= srNext;
            cnt       <= cntNext;
            pendValid <= commitNow;
            pendErr   <= errNow;
            if (commitNow) begin
                pendAddr <= srNext[11:8];
                pendData <= srNext[7:0];
            end
        end
    end

    assign digIdx = pendAddr[2:0] - 3'd1;

    always_ff @(posedge MAX7219RX_CLOCK_50 or negedge MAX7219RX_RESET_InLow) begin
        if (!MAX7219RX_RESET_InLow) begin
            for (int i = 0; i < 8; i++) begin
                digit[i] <= '0;
            end
            decodeMode  <= '0;
            intensity   <= '0;
            scanLimit   <= '0;
            shutdownN   <= 1'b0;
            displayTest <= 1'b0;
            frameValid  <= 1'b0;
            frameErr    <= 1'b0;
            frameAddr   <= '0;
            frameData   <= '0;
        end else begin
            frameValid <= pendValid;
            frameErr   <= pendErr;
            if (pendValid) begin
                frameAddr <= pendAddr;
                frameData <= pendData;
                case (pendAddr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit[digIdx] <= pendData;
                    4'h9:    decodeMode  <= pendData;
                    4'hA:    intensity   <= pendData[3:0];
                    4'hB:    scanLimit   <= pendData[2:0];
                    4'hC:    shutdownN   <= pendData[0];
                    4'hF:    displayTest <= pendData[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge MAX7219RX_CLOCK_50 or negedge MAX7219RX_RESET_InLow) begin
        if (!MAX7219RX_RESET_InLow) begin
            rdData <= '0;
        end else begin
            rdData <= digit[bus.MAX7219RX_rdAddr_In];
        end
    end

    assign bus.MAX7219RX_rdData_Out      = rdData;
    assign bus.MAX7219RX_decodeMode_Out  = decodeMode;
    assign bus.MAX7219RX_intensity_Out   = intensity;
    assign bus.MAX7219RX_scanLimit_Out   = scanLimit;
    assign bus.MAX7219RX_shutdownN_Out   = shutdownN;
    assign bus.MAX7219RX_displayTest_Out = displayTest;
    assign bus.MAX7219RX_frameValid_Out  = frameValid;
    assign bus.MAX7219RX_frameAddr_Out   = frameAddr;
    assign bus.MAX7219RX_frameData_Out   = frameData;
    assign bus.MAX7219RX_frameErr_Out    = frameErr;
endmodule

// File: tb/tb_max7219_rx_monitor.sv
// Directed bench for max7219_rx_monitor: drives MAX7219 serial frames
// and checks the shadow register file and frame event pulses.
module tb_max7219_rx_monitor;
    logic clk = 1'b0;
    logic rstN = 1'b0;

    max7219_rx_monitor_if bus();

    max7219_rx_monitor #(
        .SYNC_STAGES(2)
    ) dut (
        .MAX7219RX_CLOCK_50   (clk),
        .MAX7219RX_RESET_InLow(rstN),
        .bus                  (bus)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int vCnt = 0;
    int eCnt = 0;
    int bad = 0;
    logic pV = 1'b0;
    logic pE = 1'b0;

    // Pulse counters and pulse-shape watcher, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.MAX7219RX_frameValid_Out === 1'b1) vCnt++;
        if (bus.MAX7219RX_frameErr_Out === 1'b1) eCnt++;
        if (bus.MAX7219RX_frameValid_Out === 1'b1 && bus.MAX7219RX_frameErr_Out === 1'b1) bad++;
        if (bus.MAX7219RX_frameValid_Out === 1'b1 && pV) bad++;
        if (bus.MAX7219RX_frameErr_Out === 1'b1 && pE) bad++;
        pV = (bus.MAX7219RX_frameValid_Out === 1'b1);
        pE = (bus.MAX7219RX_frameErr_Out === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shiftBits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.MAX7219RX_din_In = v[i];
            tick(4);
            bus.MAX7219RX_clk_In = 1'b1;
            tick(4);
            bus.MAX7219RX_clk_In = 1'b0;
        end
    endtask

    // Full transfer; lat = negedges from NCS rise to the first event pulse (0 = none in 20).
    task automatic sendFrame(input logic [31:0] v, input int n, output int lat);
        bus.MAX7219RX_ncs_In = 1'b0;
        tick(4);
        shiftBits(v, n);
        tick(4);
        bus.MAX7219RX_ncs_In = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.MAX7219RX_frameValid_Out === 1'b1 || bus.MAX7219RX_frameErr_Out === 1'b1)
                lat = k;
        end
        tick(6);
    endtask

    task automatic readRow(input logic [2:0] a, output logic [7:0] d);
        bus.MAX7219RX_rdAddr_In = a;
        tick(1);
        @(negedge clk);
        d = bus.MAX7219RX_rdData_Out;
        tick(1);
    endtask

    initial begin
        int lat;
        int v0;
        int e0;
        logic [7:0] d;
        logic [7:0] rows [8];
        logic [7:0] pat [8];

        rows = '{8'h10, 8'h38, 8'h7C, 8'h7C, 8'h38, 8'h10, 8'h00, 8'h10};
        pat  = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};

        bus.MAX7219RX_din_In    = 1'b0;
        bus.MAX7219RX_clk_In    = 1'b0;
        bus.MAX7219RX_ncs_In    = 1'b1;
        bus.MAX7219RX_rdAddr_In = 3'd0;
        tick(3);
        chk("rst_intensity", 32'(bus.MAX7219RX_intensity_Out), 32'h0);
        chk("rst_shutdownN", 32'(bus.MAX7219RX_shutdownN_Out), 32'h0);
        chk("rst_frameValid", 32'(bus.MAX7219RX_frameValid_Out), 32'h0);
        chk("rst_rdData", 32'(bus.MAX7219RX_rdData_Out), 32'h0);
        rstN = 1'b1;
        tick(4);
        chk("idle_noEvents", 32'(vCnt + eCnt), 32'h0);

        // Single intensity frame
        v0 = vCnt;
        sendFrame(32'h0A07, 16, lat);
        chk("f0A07_latency", 32'(lat), 32'd5);
        chk("f0A07_intensity", 32'(bus.MAX7219RX_intensity_Out), 32'h7);
        chk("f0A07_addr", 32'(bus.MAX7219RX_frameAddr_Out), 32'hA);
        chk("f0A07_data", 32'(bus.MAX7219RX_frameData_Out), 32'h07);
        chk("f0A07_validCnt", 32'(vCnt - v0), 32'd1);

        // Eight digit rows and read-back
        for (int r = 0; r < 8; r++) begin
            sendFrame({20'h0, 4'(r + 1), rows[r]}, 16, lat);
        end
        for (int r = 0; r < 8; r++) begin
            readRow(3'(r), d);
            chk($sformatf("row%0d", r), 32'(d), 32'(rows[r]));
        end

        // No-op and unused addresses still produce frame events
        v0 = vCnt;
        sendFrame(32'h0055, 16, lat);
        chk("noop_addr", 32'(bus.MAX7219RX_frameAddr_Out), 32'h0);
        chk("noop_data", 32'(bus.MAX7219RX_frameData_Out), 32'h55);
        sendFrame(32'h0DFF, 16, lat);
        chk("addrD_addr", 32'(bus.MAX7219RX_frameAddr_Out), 32'hD);
        chk("addrD_validCnt", 32'(vCnt - v0), 32'd2);
        chk("addrD_intensity", 32'(bus.MAX7219RX_intensity_Out), 32'h7);
        readRow(3'd0, d);
        chk("noop_row0", 32'(d), 32'h10);

        // Daisy-chain overlength burst
        v0 = vCnt;
        e0 = eCnt;
        sendFrame(32'hAB0C01, 24, lat);
        chk("burst_shutdownN", 32'(bus.MAX7219RX_shutdownN_Out), 32'h1);
        chk("burst_errCnt", 32'(eCnt - e0), 32'd0);
        chk("burst_validCnt", 32'(vCnt - v0), 32'd1);
        chk("burst_addr", 32'(bus.MAX7219RX_frameAddr_Out), 32'hC);

        // Short frame
        v0 = vCnt;
        e0 = eCnt;
        sendFrame(32'h155, 9, lat);
        chk("short_errCnt", 32'(eCnt - e0), 32'd1);
        chk("short_validCnt", 32'(vCnt - v0), 32'd0);
        chk("short_latency", 32'(lat), 32'd5);
        chk("short_intensity", 32'(bus.MAX7219RX_intensity_Out), 32'h7);
        chk("short_shutdownN", 32'(bus.MAX7219RX_shutdownN_Out), 32'h1);
        chk("short_frameAddr", 32'(bus.MAX7219RX_frameAddr_Out), 32'hC);

        // Reset in the middle of a frame
        v0 = vCnt;
        e0 = eCnt;
        bus.MAX7219RX_ncs_In = 1'b0;
        tick(4);
        shiftBits(32'h0F, 8);
        tick(2);
        rstN = 1'b0;
        bus.MAX7219RX_ncs_In = 1'b1;
        #1;
        chk("midrst_intensity", 32'(bus.MAX7219RX_intensity_Out), 32'h0);
        chk("midrst_shutdownN", 32'(bus.MAX7219RX_shutdownN_Out), 32'h0);
        tick(3);
        rstN = 1'b1;
        tick(6);
        sendFrame(32'h0B05, 16, lat);
        chk("midrst_displayTest", 32'(bus.MAX7219RX_displayTest_Out), 32'h0);
        chk("midrst_scanLimit", 32'(bus.MAX7219RX_scanLimit_Out), 32'h5);
        chk("midrst_validCnt", 32'(vCnt - v0), 32'd1);
        chk("midrst_errCnt", 32'(eCnt - e0), 32'd0);

        // matrix_ctrl-style init plus one refresh of a fixed pattern
        sendFrame(32'h0C01, 16, lat);
        sendFrame(32'h0B07, 16, lat);
        sendFrame(32'h0A0A, 16, lat);
        sendFrame(32'h0900, 16, lat);
        sendFrame(32'h0F00, 16, lat);
        for (int r = 0; r < 8; r++) begin
            sendFrame({20'h0, 4'(r + 1), pat[r]}, 16, lat);
        end
        chk("mc_intensity", 32'(bus.MAX7219RX_intensity_Out), 32'hA);
        chk("mc_scanLimit", 32'(bus.MAX7219RX_scanLimit_Out), 32'h7);
        chk("mc_shutdownN", 32'(bus.MAX7219RX_shutdownN_Out), 32'h1);
        chk("mc_decodeMode", 32'(bus.MAX7219RX_decodeMode_Out), 32'h0);
        for (int r = 0; r < 8; r++) begin
            readRow(3'(r), d);
            chk($sformatf("mc_row%0d", r), 32'(d), 32'(pat[r]));
        end

        // Display test on, then a 0x9 write of a nonzero decode mode
        sendFrame(32'h0F01, 16, lat);
        sendFrame(32'h09A5, 16, lat);
        chk("dt_displayTest", 32'(bus.MAX7219RX_displayTest_Out), 32'h1);
        chk("dm_decodeMode", 32'(bus.MAX7219RX_decodeMode_Out), 32'hA5);

        chk("pulse_shape", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/max7219_rx_monitor.md
# max7219_rx_monitor

- Receive-side model of the MAX7219 serial display interface.
- Oversamples DIN/CLK/NCS with the 50 MHz system clock, deserialises 16-bit frames and applies them to a shadow MAX7219 register file: 8 digit rows plus the control registers.
- Sits opposite `matrix_ctrl`, fed by its pin outputs, so the bench and on-board debug logic can check exactly what the LED matrix was told to display.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on each serial input (≥2).

Ports (reset is asynchronous, active-low; one clock):
- MAX7219RX_CLOCK_50  in  1  system clock, 50 MHz
- MAX7219RX_RESET_InLow  in  1  async active-low reset
- MAX7219RX_din_In  in  1  serial data (MAX7219 DIN)
- MAX7219RX_clk_In  in  1  serial clock (MAX7219 CLK)
- MAX7219RX_ncs_In  in  1  chip select, active low (MAX7219 LOAD/CS)
- MAX7219RX_rdAddr_In  in  3  digit row to read back (0..7)
- MAX7219RX_rdData_Out  out  8  registered contents of digit[rdAddr]
- MAX7219RX_decodeMode_Out  out  8  register 0x9
- MAX7219RX_intensity_Out  out  4  register 0xA[3:0]
- MAX7219RX_scanLimit_Out  out  3  register 0xB[2:0]
- MAX7219RX_shutdownN_Out  out  1  register 0xC[0]; 0 means shutdown
- MAX7219RX_displayTest_Out  out  1  register 0xF[0]
- MAX7219RX_frameValid_Out  out  1  one-cycle pulse per committed frame
- MAX7219RX_frameAddr_Out  out  4  address field of the last committed frame
- MAX7219RX_frameData_Out  out  8  data field of the last committed frame
- MAX7219RX_frameErr_Out  out  1  one-cycle pulse on a short frame

## Operation
- Input conditioning:
  - Each serial input passes through a SYNC_STAGES flip-flop synchroniser.
  - One further register per line provides edge detection.
  - din is delayed identically, so it is sampled at the same instant as the clk edge.
- Bit counter: 5 bits, saturates at 16. Shift register: 16 bits, MSB first.
- NCS falling edge: bit counter ← 0. The shift register is left unchanged.
- CLK rising edge while synced NCS = 0: sr ← {sr[14:0], din}; counter ← min(counter+1, 16).
- CLK edges while NCS = 1 are ignored.
- NCS rising edge:
  - Counter ≥ 16: commit the last 16 bits shifted in (daisy-chain behaviour). addr = sr[11:8], data = sr[7:0]; sr[15:12] is ignored.
  - Counter 1..15: frameErr pulses; nothing is written.
  - Counter 0: silently ignored.
- Commit decode:
  - addr 0x0: no-op. frameValid still pulses and frameAddr/frameData still update.
  - addr 0x1..0x8: digit[addr-1] ← data.
  - 0x9: decodeMode ← data. 0xA: intensity ← data[3:0]. 0xB: scanLimit ← data[2:0]. 0xC: shutdownN ← data[0]. 0xF: displayTest ← data[0].
  - 0xD, 0xE: no register write; frameValid still pulses.
- Simultaneous CLK rise and NCS rise detected in the same cycle: the shift is applied first, and the commit uses the updated sr and counter.
- Read port: rdData ← digit[rdAddr] registered every cycle. A same-cycle commit to that row is visible one cycle later.

## Timing
- Reset values (asynchronous, immediate):
  - All digits, decodeMode, intensity, scanLimit, shutdownN, displayTest, frameAddr, frameData, rdData = 0.
  - frameValid = frameErr = 0.
  - Counter = 0, sr = 0, synchronisers = 0.
  - NCS synchroniser resets to 1 (deselected), so no false edge is seen after reset.
- Pin edge to internal edge detect: SYNC_STAGES+1 cycles (3 at default).
- NCS rise at pin to register update: SYNC_STAGES+2 cycles. frameValid and the new register value appear in the same cycle.
- Serial clock requirement: high and low phases each ≥ SYNC_STAGES+1 system clocks. din must be stable ≥1 system clock either side of the CLK rise. Faster input is out of spec with undefined results, but no lockup.
- Reset asserted mid-frame: partial frame discarded, no frameErr pulse. After release, the receiver waits for the next NCS fall.
- frameValid and frameErr are never high together and never longer than 1 cycle.

## Test plan
- Single frame 0x0A07 (NCS low, 16 bits, NCS high) -> intensity = 7, frameValid pulses once, frameAddr = 0xA, frameData = 0x07, 5 cycles after NCS rise.
- Eight frames 0x0110..0x0810 carrying rows 0x10,0x38,0x7C,0x7C,0x38,0x10,0x00,0x10 -> rdData over rdAddr 0..7 reads back those bytes exactly.
- 24-bit burst ending in 0x0C01 (daisy-chain overlength) -> shutdownN = 1, frameErr stays 0.
- 9-bit frame -> frameErr pulses once, all registers unchanged, frameValid stays 0.
- Reset asserted after 8 bits of 0x0F01, then released, then a full frame 0x0B05 sent -> displayTest = 0, scanLimit = 5, exactly one frameValid.
- `matrix_ctrl` driven with intensity 4'hA and a fixed pattern, its pins wired to this block -> intensity = 0xA and all eight digits match the pattern after one refresh.
